alu_operand_collector: RTL and testbench

//  Upstream stage of the ALU: gathers OPA/OPB, which may arrive on different cycles, plus CMD/MODE.

---
 rtl/alu_pkg.sv | 15 +
 rtl/alu_operand_collector_if.sv | 30 +++
 rtl/alu_opcol_timer.sv | 22 ++
 rtl/alu_operand_collector.sv | 106 ++++++++++
 tb/tb_alu_operand_collector.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared types and widths for the ALU operand collector.
//   DW/CW       operand and command widths used by the collector and its interface
//   opcol_state_e collector FSM states
//   alu_op_t    one complete ALU operation as held by the collector
package alu_pkg;
  localparam int DW = 8;
  localparam int CW = 4;
  typedef enum logic [1:0] {IDLE, WAIT_A, WAIT_B, ISSUE} opcol_state_e;
  typedef struct packed {
    logic [DW-1:0] opa;
    logic [DW-1:0] opb;
    logic [CW-1:0] cmd;
    logic          mode;
  } alu_op_t;
endpackage

// File: rtl/alu_operand_collector_if.sv
// alu_operand_collector_if: operand-in and operation-out handshake bundle.
//   in_valid[0]/[1]  OPA/OPB valid          in_opa/in_opb  operands
//   in_cmd/in_mode   command and mode       in_unary       command needs OPA only
//   in_ready         collector accepts      out_valid/out_ready  operation handshake
//   out_opa/out_opb/out_cmd/out_mode        collected operation
//   slave = collector side, master = upstream source plus ALU sink
interface alu_operand_collector_if;
  import alu_pkg::*;
  logic [1:0]    in_valid;
  logic [DW-1:0] in_opa;
  logic [DW-1:0] in_opb;
  logic [CW-1:0] in_cmd;
  logic          in_mode;
  logic          in_unary;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_opa;
  logic [DW-1:0] out_opb;
  logic [CW-1:0] out_cmd;
  logic          out_mode;
  modport slave (
    input  in_valid, in_opa, in_opb, in_cmd, in_mode, in_unary, out_ready,
    output in_ready, out_valid, out_opa, out_opb, out_cmd, out_mode
  );
  modport master (
    output in_valid, in_opa, in_opb, in_cmd, in_mode, in_unary, out_ready,
    input  in_ready, out_valid, out_opa, out_opb, out_cmd, out_mode
  );
endinterface

// File: rtl/alu_opcol_timer.sv
// alu_opcol_timer: wait counter for the missing operand.
//   clk, rst (async, active-low), cen  clock enable
//   clr      restart from zero on the next enabled edge
//   en       count one enabled cycle
//   expired  counter has reached TIMEOUT-1
module alu_opcol_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic cen,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CNTW = $clog2(TIMEOUT);
  logic [CNTW-1:0] cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (cen) cnt <= clr ? '0 : en ? cnt + CNTW'(1) : cnt;
  assign expired = cnt == CNTW'(TIMEOUT - 1);
endmodule

// File: rtl/alu_operand_collector.sv
// alu_operand_collector: gathers OPA/OPB/CMD/MODE and issues one ALU operation.
//   clk          rising-edge clock
//   rst          asynchronous, active-low reset
//   cen          clock enable; 0 freezes all state
//   bus          alu_operand_collector_if.slave (operand input + operation output)
//   timeout_err  one-cycle pulse when a partial operation is dropped
//   stat_issued / stat_timeouts  saturating event counters, only with ALU_OPCOL_STATS_EN
// DW/CW come from alu_pkg; TIMEOUT (>=2) is the wait budget in enabled cycles.
module alu_operand_collector
  import alu_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cen,
  alu_operand_collector_if.slave  bus,
  output logic                    timeout_err
`ifdef ALU_OPCOL_STATS_EN
  ,
  output logic [15:0]             stat_issued,
  output logic [15:0]             stat_timeouts
`endif
);
  opcol_state_e state, state_nx;
  alu_op_t op, op_nx;
  logic waiting, expired, fire, drop;
  assign waiting = state == WAIT_A || state == WAIT_B;
  assign fire = state == ISSUE && bus.out_ready && cen;
  alu_opcol_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk(clk),
    .rst(rst),
    .cen(cen),
    .clr(!waiting),
    .en(waiting),
    .expired(expired)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state       <= IDLE;
      op          <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nx;
      op          <= op_nx;
      timeout_err <= cen ? drop : timeout_err;
    end
  // A unary op zeroes OPB at first capture, so no unary flag needs to be held.
  always_comb begin
    state_nx = state;
    op_nx    = op;
    drop     = 1'b0;
    if (cen)
      unique case (state)
        IDLE:
          if (bus.in_valid != 2'b00) begin
            op_nx.opa  = bus.in_valid[0] ? bus.in_opa : '0;
            op_nx.opb  = bus.in_valid[1] && !bus.in_unary ? bus.in_opb : '0;
            op_nx.cmd  = bus.in_cmd;
            op_nx.mode = bus.in_mode;
            state_nx   = bus.in_valid[0] && (bus.in_valid[1] || bus.in_unary) ? ISSUE :
                         bus.in_valid[0] ? WAIT_B : WAIT_A;
          end
        WAIT_B:
          if (bus.in_valid[1]) begin
            op_nx.opb = bus.in_opb;
            state_nx  = ISSUE;
          end else if (expired) begin
            op_nx    = '0;
            drop     = 1'b1;
            state_nx = IDLE;
          end
        WAIT_A:
          if (bus.in_valid[0]) begin
            op_nx.opa = bus.in_opa;
            state_nx  = ISSUE;
          end else if (expired) begin
            op_nx    = '0;
            drop     = 1'b1;
            state_nx = IDLE;
          end
        ISSUE:
          state_nx = bus.out_ready ? IDLE : ISSUE;
      endcase
  end
  // in_ready is forced low while reset is asserted so every output reads 0.
  assign bus.in_ready  = rst && state != ISSUE;
  assign bus.out_valid = state == ISSUE;
  assign bus.out_opa   = op.opa;
  assign bus.out_opb   = op.opb;
  assign bus.out_cmd   = op.cmd;
  assign bus.out_mode  = op.mode;
`ifdef ALU_OPCOL_STATS_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      stat_issued   <= '0;
      stat_timeouts <= '0;
    end else begin
      if (fire && stat_issued != 16'hFFFF) stat_issued <= stat_issued + 16'd1;
      if (drop && stat_timeouts != 16'hFFFF) stat_timeouts <= stat_timeouts + 16'd1;
    end
`else
  logic unused_fire;
  assign unused_fire = fire;
`endif
endmodule

// File: tb/tb_alu_operand_collector.sv
// tb_alu_operand_collector: directed scoreboard bench for alu_operand_collector.
module tb_alu_operand_collector;
  typedef struct {
    logic [7:0] opa;
    logic [7:0] opb;
    logic [3:0] cmd;
    logic       mode;
  } exp_t;
  logic clk = 1'b0;
  logic rst;
  logic cen;
  logic timeout_err;
`ifdef ALU_OPCOL_STATS_EN
  logic [15:0] stat_issued;
  logic [15:0] stat_timeouts;
`endif
  int tests = 0;
  int fails = 0;
  int exp_to = 0;
  exp_t sb[$];
  exp_t mon_e;
  alu_operand_collector_if bus();
  alu_operand_collector #(.TIMEOUT(16)) dut (
    .clk(clk),
    .rst(rst),
    .cen(cen),
    .bus(bus),
    .timeout_err(timeout_err)
`ifdef ALU_OPCOL_STATS_EN
    ,
    .stat_issued(stat_issued),
    .stat_timeouts(stat_timeouts)
`endif
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [1:0] v, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] c, input logic m, input logic u);
    bus.in_valid = v;
    bus.in_opa   = a;
    bus.in_opb   = b;
    bus.in_cmd   = c;
    bus.in_mode  = m;
    bus.in_unary = u;
  endtask
  task automatic expect_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] c, input logic m);
    exp_t e;
    e.opa = a; e.opb = b; e.cmd = c; e.mode = m;
    sb.push_back(e);
  endtask
  task automatic handshake();
    bus.in_valid  = 2'b00;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("hs_out_valid", 32'(bus.out_valid), 32'd0);
    check("hs_in_ready", 32'(bus.in_ready), 32'd1);
  endtask
  // Monitor: compare every completed output handshake and timeout pulse to the scoreboard.
  always @(negedge clk)
    if (rst) begin
      if (cen && bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_unexpected: got op %h/%h with none expected", bus.out_opa, bus.out_opb);
        end else begin
          mon_e = sb.pop_front();
          check("out_opa", 32'(bus.out_opa), 32'(mon_e.opa));
          check("out_opb", 32'(bus.out_opb), 32'(mon_e.opb));
          check("out_cmd", 32'(bus.out_cmd), 32'(mon_e.cmd));
          check("out_mode", 32'(bus.out_mode), 32'(mon_e.mode));
        end
      end
      if (timeout_err) begin
        tests++;
        if (exp_to == 0) begin
          fails++;
          $display("FAIL timeout_unexpected: got timeout_err=1 expected 0");
        end else exp_to--;
      end
    end
  initial begin
    rst = 1'b0;
    cen = 1'b1;
    bus.out_ready = 1'b0;
    drive(2'b00, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_timeout", 32'(timeout_err), 32'd0);
    check("rst_out_opa", 32'(bus.out_opa), 32'd0);
    rst = 1'b1;
    #1;
    check("rel_in_ready", 32'(bus.in_ready), 32'd1);
    // 1: both operands together -> out_valid next cycle
    drive(2'b11, 8'h12, 8'h34, 4'h0, 1'b1, 1'b0);
    expect_op(8'h12, 8'h34, 4'h0, 1'b1);
    step();
    check("t1_latency", 32'(bus.out_valid), 32'd1);
    handshake();
    // 2: A first, B five cycles later; re-sent A and later cmd ignored
    drive(2'b01, 8'hAA, 8'h00, 4'h3, 1'b0, 1'b0);
    step();
    drive(2'b01, 8'hFF, 8'h00, 4'h9, 1'b1, 1'b0);
    step();
    drive(2'b00, 8'h00, 8'h00, 4'h9, 1'b1, 1'b0);
    repeat (3) step();
    check("t2_wait_valid", 32'(bus.out_valid), 32'd0);
    drive(2'b10, 8'h00, 8'h55, 4'hF, 1'b1, 1'b0);
    expect_op(8'hAA, 8'h55, 4'h3, 1'b0);
    step();
    check("t2_valid", 32'(bus.out_valid), 32'd1);
    handshake();
    // 3: A then nothing for 16 cycles -> single timeout pulse
    drive(2'b01, 8'h77, 8'h00, 4'h1, 1'b0, 1'b0);
    step();
    drive(2'b00, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0);
    exp_to++;
    repeat (15) step();
    check("t3_not_yet", 32'(timeout_err), 32'd0);
    step();
    check("t3_pulse", 32'(timeout_err), 32'd1);
    check("t3_idle", 32'(bus.in_ready), 32'd1);
    check("t3_no_valid", 32'(bus.out_valid), 32'd0);
    step();
    check("t3_one_pulse", 32'(timeout_err), 32'd0);
    check("t3_opa_cleared", 32'(bus.out_opa), 32'd0);
    // 3b: B arrives on the expiry cycle -> arrival wins
    drive(2'b01, 8'h21, 8'h00, 4'h6, 1'b1, 1'b0);
    step();
    drive(2'b00, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0);
    repeat (15) step();
    drive(2'b10, 8'h00, 8'h43, 4'h0, 1'b0, 1'b0);
    expect_op(8'h21, 8'h43, 4'h6, 1'b1);
    step();
    check("t3b_valid", 32'(bus.out_valid), 32'd1);
    check("t3b_no_err", 32'(timeout_err), 32'd0);
    handshake();
    // 4: stall in ISSUE; new inputs are not accepted
    drive(2'b11, 8'h5A, 8'hA5, 4'h7, 1'b1, 1'b0);
    expect_op(8'h5A, 8'hA5, 4'h7, 1'b1);
    step();
    drive(2'b11, 8'h01, 8'h02, 4'h8, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("t4_valid", 32'(bus.out_valid), 32'd1);
      check("t4_opa", 32'(bus.out_opa), 32'h5A);
      check("t4_opb", 32'(bus.out_opb), 32'hA5);
      check("t4_in_ready", 32'(bus.in_ready), 32'd0);
    end
    handshake();
    // 5: cen=0 freezes the wait counter and ignores B
    drive(2'b01, 8'hC3, 8'h00, 4'h2, 1'b0, 1'b0);
    step();
    drive(2'b00, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0);
    repeat (10) step();
    cen = 1'b0;
    drive(2'b10, 8'h00, 8'hEE, 4'h0, 1'b0, 1'b0);
    repeat (10) step();
    check("t5_frozen_valid", 32'(bus.out_valid), 32'd0);
    check("t5_frozen_ready", 32'(bus.in_ready), 32'd1);
    cen = 1'b1;
    drive(2'b00, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0);
    repeat (5) step();
    check("t5_no_timeout", 32'(timeout_err), 32'd0);
    drive(2'b10, 8'h00, 8'h3C, 4'h0, 1'b0, 1'b0);
    expect_op(8'hC3, 8'h3C, 4'h2, 1'b0);
    step();
    check("t5_valid", 32'(bus.out_valid), 32'd1);
    bus.in_valid  = 2'b00;
    bus.out_ready = 1'b1;
    cen = 1'b0;
    step();
    check("t5_gated_hs", 32'(bus.out_valid), 32'd1);
    cen = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("t5_hs_done", 32'(bus.out_valid), 32'd0);
    // unary: OPB forced to zero
    drive(2'b01, 8'h99, 8'h88, 4'hB, 1'b1, 1'b1);
    expect_op(8'h99, 8'h00, 4'hB, 1'b1);
    step();
    check("un1_valid", 32'(bus.out_valid), 32'd1);
    handshake();
    drive(2'b11, 8'h44, 8'h88, 4'hC, 1'b0, 1'b1);
    expect_op(8'h44, 8'h00, 4'hC, 1'b0);
    step();
    handshake();
    // 6: reset during WAIT_A
    drive(2'b10, 8'h00, 8'h66, 4'hD, 1'b1, 1'b0);
    step();
    drive(2'b00, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0);
    repeat (3) step();
    check("t6_opb_held", 32'(bus.out_opb), 32'h66);
`ifdef ALU_OPCOL_STATS_EN
    check("t6_stat_issued", 32'(stat_issued), 32'd7);
    check("t6_stat_timeouts", 32'(stat_timeouts), 32'd1);
`endif
    rst = 1'b0;
    #1;
    check("t6_out_valid", 32'(bus.out_valid), 32'd0);
    check("t6_in_ready", 32'(bus.in_ready), 32'd0);
    check("t6_out_opb", 32'(bus.out_opb), 32'd0);
    check("t6_out_cmd", 32'(bus.out_cmd), 32'd0);
    check("t6_timeout", 32'(timeout_err), 32'd0);
`ifdef ALU_OPCOL_STATS_EN
    check("t6_stat_issued_clr", 32'(stat_issued), 32'd0);
    check("t6_stat_timeouts_clr", 32'(stat_timeouts), 32'd0);
`endif
    repeat (2) step();
    rst = 1'b1;
    repeat (20) step();
    check("t6_after_ready", 32'(bus.in_ready), 32'd1);
    check("t6_after_valid", 32'(bus.out_valid), 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);
    check("timeouts_seen", 32'(exp_to), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
